inst_queue: RTL and testbench

- Decoupling FIFO between instruction fetch and decode/issue in the dual-issue pipeline.
- Accepts 0–2 fetched instructions per cycle with their PCs and delay-slot flags.
- Presents the two oldest entries to the issue stage, which pops 1 or 2 per cycle according to its single/dual issue decision.
- A flush (exception or failed branch prediction) empties the queue in one cycle.

---
 rtl/inst_queue_pkg.sv | 31 +++
 rtl/inst_queue_ram.sv | 40 ++++
 rtl/inst_queue.sv | 150 +++++++++++++++
 tb/tb_inst_queue.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_queue_pkg.sv
//============================================================================
// Module  : inst_queue_pkg
// Brief   : Shared issue-mode/flush encodings and entry layout for inst_queue.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

package inst_queue_pkg;

  localparam logic SINGLE_ISSUE = 1'b0;
  localparam logic DUAL_ISSUE   = 1'b1;
  localparam logic FLUSH        = 1'b1;
  localparam logic RST_ENABLE   = 1'b1;

  localparam int INST_BUS_W      = 32;
  localparam int INST_ADDR_BUS_W = 32;
  localparam int INST_QUEUE_ENTRY_W = 1 + INST_ADDR_BUS_W + INST_BUS_W;

  typedef struct packed {
    logic                       dslot;
    logic [INST_ADDR_BUS_W-1:0] pc;
    logic [INST_BUS_W-1:0]      inst;
  } iq_entry_t;

  function automatic iq_entry_t mask_entry(input iq_entry_t e, input logic v);
    return v ? e : '0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/inst_queue_ram.sv
//============================================================================
// Module  : inst_queue_ram
// Brief   : DEPTH x 65 entry array, two write ports, two async read ports.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module inst_queue_ram
  import inst_queue_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we1,
  input  logic [PTR_W-1:0] waddr1,
  input  iq_entry_t        wdata1,
  input  logic             we2,
  input  logic [PTR_W-1:0] waddr2,
  input  iq_entry_t        wdata2,
  input  logic [PTR_W-1:0] raddr1,
  output iq_entry_t        rdata1,
  input  logic [PTR_W-1:0] raddr2,
  output iq_entry_t        rdata2
);

  iq_entry_t mem_q [DEPTH];

  // The two write addresses are always distinct (tail and tail+1).
  always_ff @(posedge clk) begin
    if (we1) mem_q[waddr1] <= wdata1;
    if (we2) mem_q[waddr2] <= wdata2;
  end

  assign rdata1 = mem_q[raddr1];
  assign rdata2 = mem_q[raddr2];

endmodule

`default_nettype wire

// File: rtl/inst_queue.sv
//============================================================================
// Module  : inst_queue
// Brief   : Fetch-to-issue instruction FIFO, 0-2 pushes and 0-2 pops per
//           cycle, single-cycle flush. INST_QUEUE_STATS_EN adds a stall counter.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module inst_queue
  import inst_queue_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push_valid1,
  input  logic              push_valid2,
  input  logic [31:0]       push_inst1,
  input  logic [31:0]       push_inst2,
  input  logic [31:0]       push_pc1,
  input  logic [31:0]       push_pc2,
  input  logic              push_dslot1,
  input  logic              push_dslot2,
  output logic              full_o,
  input  logic              pop_req,
  input  logic              pop_mode,
  output logic              valid1_o,
  output logic              valid2_o,
  output logic [31:0]       inst1_o,
  output logic [31:0]       inst2_o,
  output logic [31:0]       pc1_o,
  output logic [31:0]       pc2_o,
  output logic              dslot1_o,
  output logic              dslot2_o,
`ifdef INST_QUEUE_STATS_EN
  output logic [31:0]       stall_cycles_o,
`endif
  output logic [PTR_W:0]    count_o
);

  localparam logic [PTR_W:0] CNT_ONE      = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] CNT_TWO      = (PTR_W+1)'(2);
  localparam logic [PTR_W:0] CNT_FULL_LIM = (PTR_W+1)'(DEPTH-2);
  localparam logic [PTR_W:0] CNT_MAX      = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  logic       full;
  logic       push_ok;
  logic [1:0] push_n;
  logic [1:0] pop_n;
  iq_entry_t  wdata1, wdata2, rdata1, rdata2;

  always_comb begin
    full    = (count_q > CNT_FULL_LIM);
    // A lone slot-2 push is illegal and ignored.
    push_ok = push_valid1 && !full && (flush != FLUSH);
    push_n  = push_ok ? (push_valid2 ? 2'd2 : 2'd1) : 2'd0;

    pop_n = 2'd0;
    if (pop_req && (flush != FLUSH)) begin
      if ((pop_mode == DUAL_ISSUE) && (count_q >= CNT_TWO)) pop_n = 2'd2;
      else if (count_q >= CNT_ONE)                          pop_n = 2'd1;
    end

    head_d  = head_q + PTR_W'(pop_n);
    tail_d  = tail_q + PTR_W'(push_n);
    count_d = count_q + (PTR_W+1)'(push_n) - (PTR_W+1)'(pop_n);

    if (flush == FLUSH) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign wdata1 = '{dslot: push_dslot1, pc: push_pc1, inst: push_inst1};
  assign wdata2 = '{dslot: push_dslot2, pc: push_pc2, inst: push_inst2};

  inst_queue_ram #(.DEPTH(DEPTH)) u_ram (
    .clk    (clk),
    .we1    (push_ok),
    .waddr1 (tail_q),
    .wdata1 (wdata1),
    .we2    (push_ok && push_valid2),
    .waddr2 (tail_q + PTR_W'(1)),
    .wdata2 (wdata2),
    .raddr1 (head_q),
    .rdata1 (rdata1),
    .raddr2 (head_q + PTR_W'(1)),
    .rdata2 (rdata2)
  );

  iq_entry_t out1, out2;

  always_comb begin
    valid1_o = (count_q >= CNT_ONE);
    valid2_o = (count_q >= CNT_TWO);
    out1     = mask_entry(rdata1, valid1_o);
    out2     = mask_entry(rdata2, valid2_o);
  end

  assign inst1_o  = out1.inst;
  assign pc1_o    = out1.pc;
  assign dslot1_o = out1.dslot;
  assign inst2_o  = out2.inst;
  assign pc2_o    = out2.pc;
  assign dslot2_o = out2.dslot;
  assign full_o   = full;
  assign count_o  = count_q;

`ifdef INST_QUEUE_STATS_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  // Saturating; only reset clears it, flush leaves it alone.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (push_valid1 && full && (stall_cycles_q != 32'hFFFF_FFFF))
      stall_cycles_d = stall_cycles_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) stall_cycles_q <= '0;
    else                   stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles_o = stall_cycles_q;
`endif

  a_count_max: assert property (@(posedge clk) disable iff (rst) count_q <= CNT_MAX);

endmodule

`default_nettype wire

// File: tb/tb_inst_queue.sv
//============================================================================
// Module  : tb_inst_queue
// Brief   : Directed + random scoreboard bench for inst_queue.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module tb_inst_queue;
  import inst_queue_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        push_valid1, push_valid2;
  logic [31:0] push_inst1, push_inst2, push_pc1, push_pc2;
  logic        push_dslot1, push_dslot2;
  logic        full_o, pop_req, pop_mode;
  logic        valid1_o, valid2_o;
  logic [31:0] inst1_o, inst2_o, pc1_o, pc2_o;
  logic        dslot1_o, dslot2_o;
  logic [3:0]  count_o;
`ifdef INST_QUEUE_STATS_EN
  logic [31:0] stall_cycles_o;
`endif

  always #5 clk = ~clk;

  inst_queue #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .push_valid1    (push_valid1),
    .push_valid2    (push_valid2),
    .push_inst1     (push_inst1),
    .push_inst2     (push_inst2),
    .push_pc1       (push_pc1),
    .push_pc2       (push_pc2),
    .push_dslot1    (push_dslot1),
    .push_dslot2    (push_dslot2),
    .full_o         (full_o),
    .pop_req        (pop_req),
    .pop_mode       (pop_mode),
    .valid1_o       (valid1_o),
    .valid2_o       (valid2_o),
    .inst1_o        (inst1_o),
    .inst2_o        (inst2_o),
    .pc1_o          (pc1_o),
    .pc2_o          (pc2_o),
    .dslot1_o       (dslot1_o),
    .dslot2_o       (dslot2_o),
`ifdef INST_QUEUE_STATS_EN
    .stall_cycles_o (stall_cycles_o),
`endif
    .count_o        (count_o)
  );

  iq_entry_t mq[$];
  int        checks    = 0;
  int        failures  = 0;
  int        exp_stall = 0;
  int        seq       = 0;

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic iq_entry_t mk(input logic [31:0] inst, input logic [31:0] pc, input logic ds);
    iq_entry_t e;
    e.inst = inst; e.pc = pc; e.dslot = ds;
    return e;
  endfunction

  function automatic iq_entry_t gen();
    seq++;
    return mk(32'hA000_0000 + 32'(seq), 32'h8000_0000 + 32'(seq * 4), seq[0]);
  endfunction

  task automatic check_outputs(input string tag);
    iq_entry_t e1, e2;
    int n;
    n  = mq.size();
    e1 = '0;
    e2 = '0;
    if (n >= 1) e1 = mq[0];
    if (n >= 2) e2 = mq[1];
    chk({tag, ".count"},  65'(count_o),  65'(n));
    chk({tag, ".full"},   65'(full_o),   65'((DEPTH - n) < 2));
    chk({tag, ".valid1"}, 65'(valid1_o), 65'(n >= 1));
    chk({tag, ".valid2"}, 65'(valid2_o), 65'(n >= 2));
    chk({tag, ".entry1"}, {dslot1_o, pc1_o, inst1_o}, e1);
    chk({tag, ".entry2"}, {dslot2_o, pc2_o, inst2_o}, e2);
  endtask

  task automatic cycle(input logic pv1, input logic pv2, input iq_entry_t a, input iq_entry_t b,
                       input logic preq, input logic pmode, input logic fl);
    int n, pn;
    push_valid1 = pv1;  push_valid2 = pv2;
    push_inst1  = a.inst; push_pc1 = a.pc; push_dslot1 = a.dslot;
    push_inst2  = b.inst; push_pc2 = b.pc; push_dslot2 = b.dslot;
    pop_req = preq; pop_mode = pmode; flush = fl;
    n = mq.size();
    if (pv1 && (DEPTH - n) < 2) exp_stall++;
    if (fl) begin
      mq.delete();
    end else begin
      pn = 0;
      if (preq) pn = (pmode == DUAL_ISSUE && n >= 2) ? 2 : ((n >= 1) ? 1 : 0);
      for (int i = 0; i < pn; i++) void'(mq.pop_front());
      if (pv1 && (DEPTH - n) >= 2) begin
        mq.push_back(a);
        if (pv2) mq.push_back(b);
      end
    end
    @(posedge clk); #1;
    push_valid1 = 1'b0; push_valid2 = 1'b0; pop_req = 1'b0; flush = 1'b0;
  endtask

  task automatic push1();
    cycle(1'b1, 1'b0, gen(), '0, 1'b0, SINGLE_ISSUE, 1'b0);
  endtask

  task automatic push2();
    iq_entry_t a, b;
    a = gen(); b = gen();
    cycle(1'b1, 1'b1, a, b, 1'b0, SINGLE_ISSUE, 1'b0);
  endtask

  task automatic pop(input logic mode);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, mode, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mq.delete();
    exp_stall = 0;
  endtask

  initial begin
    iq_entry_t third, a, b;
    rst = 1'b1; flush = 1'b0;
    push_valid1 = 1'b0; push_valid2 = 1'b0;
    push_inst1 = '0; push_inst2 = '0; push_pc1 = '0; push_pc2 = '0;
    push_dslot1 = 1'b0; push_dslot2 = 1'b0;
    pop_req = 1'b0; pop_mode = SINGLE_ISSUE;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_outputs("reset");

    cycle(1'b1, 1'b1, mk(32'h2401_0001, 32'hBFC0_0000, 1'b0),
          mk(32'h2402_0002, 32'hBFC0_0004, 1'b0), 1'b0, SINGLE_ISSUE, 1'b0);
    check_outputs("first_push");
    chk("first_pc1",   65'(pc1_o),   65'(32'hBFC0_0000));
    chk("first_pc2",   65'(pc2_o),   65'(32'hBFC0_0004));
    chk("first_count", 65'(count_o), 65'(2));

    push2(); push2(); push1();
    check_outputs("fill7");
    chk("fill7_full", 65'(full_o), 65'(1));
    push2();
    check_outputs("drop_push");
    chk("drop_count", 65'(count_o), 65'(7));
    pop(SINGLE_ISSUE);
    check_outputs("pop_single");
    chk("pop_single_count", 65'(count_o), 65'(6));
    chk("pop_single_full",  65'(full_o),  65'(0));

    pop(DUAL_ISSUE);   check_outputs("drain4");
    pop(DUAL_ISSUE);   check_outputs("drain2");
    pop(SINGLE_ISSUE); check_outputs("drain1");
    pop(DUAL_ISSUE);
    check_outputs("dual_on_one");
    chk("dual_on_one_valid1", 65'(valid1_o), 65'(0));

    // head and tail now sit at index 7, so the next entries straddle the wrap
    push2();
    check_outputs("wrap_read");
    push1();
    check_outputs("count3");
    third = mq[2];
    a = gen(); b = gen();
    cycle(1'b1, 1'b1, a, b, 1'b1, DUAL_ISSUE, 1'b0);
    check_outputs("push_pop");
    chk("push_pop_count", 65'(count_o), 65'(3));
    chk("push_pop_head",  65'(inst1_o), 65'(third.inst));

    push2();
    check_outputs("count5");
    a = gen(); b = gen();
    cycle(1'b1, 1'b1, a, b, 1'b0, SINGLE_ISSUE, 1'b1);
    check_outputs("flush");
    chk("flush_count",  65'(count_o),  65'(0));
    chk("flush_valid1", 65'(valid1_o), 65'(0));
    chk("flush_full",   65'(full_o),   65'(0));
    push1();
    check_outputs("after_flush");

    push2(); push2();
    do_reset();
    check_outputs("mid_reset");

    push2(); push2(); push2(); push1();
    repeat (10) push2();
    repeat (3) cycle(1'b0, 1'b0, '0, '0, 1'b0, SINGLE_ISSUE, 1'b0);
    check_outputs("stall_hold");
`ifdef INST_QUEUE_STATS_EN
    chk("stall_10", 65'(stall_cycles_o), 65'(exp_stall));
    chk("stall_10_const", 65'(stall_cycles_o), 65'(10));
    cycle(1'b0, 1'b0, '0, '0, 1'b0, SINGLE_ISSUE, 1'b1);
    chk("stall_after_flush", 65'(stall_cycles_o), 65'(10));
    do_reset();
    chk("stall_after_rst", 65'(stall_cycles_o), 65'(0));
`else
    cycle(1'b0, 1'b0, '0, '0, 1'b0, SINGLE_ISSUE, 1'b1);
    check_outputs("hold_flush");
`endif

    for (int k = 0; k < 80; k++) begin
      a = gen(); b = gen();
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, b,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 19) == 0));
      check_outputs("random");
    end
`ifdef INST_QUEUE_STATS_EN
    chk("stall_random", 65'(stall_cycles_o), 65'(exp_stall));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
